// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous-read memory between the
// instruction-fetch port (read-only) and the load/store port (read/write).
// One access at a time: IDLE (accept) -> ISSUE (mem_request) -> RESP (rsp pulse).
// Build option: define MEM_ARB_RR_EN for round-robin arbitration; otherwise
// D has fixed priority, with a MAX_WAIT starvation guard for the I port.
module mem_arbiter #(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    input  logic [31:0] i_req_addr,
    output logic        i_req_ready,
    output logic        i_rsp_valid,
    output logic [31:0] i_rsp_rdata,
    input  logic        d_req_valid,
    input  logic        d_req_write,
    input  logic [31:0] d_req_addr,
    input  logic [31:0] d_req_wdata,
    output logic        d_req_ready,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_rdata,
    output logic [31:0] mem_address,
    output logic        mem_request,
    output logic        mem_write,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_sync_read_data
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

    state_t      state_q, state_d;
    logic        grant_i, grant_d, accept, idle;
    logic        owner_d_q;   // 1 = load/store port owns the in-flight access
    logic        write_q;
    logic [31:0] addr_q, wdata_q;
    logic        mem_req_q, mem_write_q, i_rsp_q, d_rsp_q;

    assign idle   = (state_q == IDLE);
    assign accept = grant_i | grant_d;

`ifdef MEM_ARB_RR_EN
    logic last_d_q;

    // Round-robin: on contention the port that did not win last time goes.
    always_comb begin
        grant_d = idle && d_req_valid && !(i_req_valid && last_d_q);
        grant_i = idle && i_req_valid && !grant_d;
    end

    // Remember the most recent winner; reset treats D as last winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      last_d_q <= 1'b1;
        else if (accept) last_d_q <= grant_d;
    end
`else
    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);
    logic [7:0] wait_cnt_q, wait_cnt_d;

    // Fixed D priority unless I has already lost MAX_WAIT contended rounds.
    always_comb begin
        grant_d    = idle && d_req_valid && !(i_req_valid && (wait_cnt_q == MAX_WAIT_C));
        grant_i    = idle && i_req_valid && !grant_d;
        wait_cnt_d = wait_cnt_q;
        if (grant_i)
            wait_cnt_d = 8'd0;
        else if (grant_d && i_req_valid && (wait_cnt_q != 8'hFF))
            wait_cnt_d = wait_cnt_q + 8'd1;
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_cnt_q <= 8'd0;
        else        wait_cnt_q <= wait_cnt_d;
    end
`endif

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: strictly IDLE -> ISSUE -> RESP -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latch the winning request and register the memory strobe / response pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_d_q   <= 1'b1;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_write_q <= 1'b0;
            i_rsp_q     <= 1'b0;
            d_rsp_q     <= 1'b0;
        end else begin
            if (accept) begin
                owner_d_q <= grant_d;
                write_q   <= grant_d & d_req_write;
                addr_q    <= grant_d ? d_req_addr : i_req_addr;
                wdata_q   <= grant_d ? d_req_wdata : 32'd0;
            end
            mem_req_q   <= accept;
            mem_write_q <= grant_d & d_req_write;
            i_rsp_q     <= (state_q == ISSUE) && !owner_d_q;
            d_rsp_q     <= (state_q == ISSUE) && owner_d_q;
        end
    end

    assign i_req_ready    = grant_i;
    assign d_req_ready    = grant_d;
    assign mem_request    = mem_req_q;
    assign mem_write      = mem_write_q;
    assign mem_address    = addr_q;
    assign mem_write_data = wdata_q;
    assign i_rsp_valid    = i_rsp_q;
    assign d_rsp_valid    = d_rsp_q;
    // Read data comes straight off the memory's output register in RESP.
    assign i_rsp_rdata    = i_rsp_q ? mem_sync_read_data : 32'd0;
    assign d_rsp_rdata    = (d_rsp_q && !write_q) ? mem_sync_read_data : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed steps plus randomized traffic checked
// against a transaction-level model (winner rule + reference memory contents).
module tb_mem_arbiter;
    localparam int MW = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req_valid = 1'b0, d_req_valid = 1'b0, d_req_write = 1'b0;
    logic [31:0] i_req_addr = '0, d_req_addr = '0, d_req_wdata = '0;
    logic        i_req_ready, i_rsp_valid, d_req_ready, d_rsp_valid;
    logic [31:0] i_rsp_rdata, d_rsp_rdata;
    logic [31:0] mem_address, mem_write_data, mem_sync_read_data;
    logic        mem_request, mem_write;

    int tests = 0;
    int fails = 0;

    mem_arbiter #(.MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
        .i_rsp_valid(i_rsp_valid), .i_rsp_rdata(i_rsp_rdata),
        .d_req_valid(d_req_valid), .d_req_write(d_req_write), .d_req_addr(d_req_addr),
        .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
        .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata),
        .mem_address(mem_address), .mem_request(mem_request), .mem_write(mem_write),
        .mem_write_data(mem_write_data), .mem_sync_read_data(mem_sync_read_data)
    );

    always #5 clk = ~clk;

    // Memory contents before any write: a fixed scramble of the address.
    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    // Behavioural single-port memory with a synchronous read port.
    logic [31:0] mem [logic [31:0]];
    initial mem_sync_read_data = '0;
    always @(posedge clk) begin
        if (mem_request) begin
            if (mem_write) mem[mem_address] = mem_write_data;
            else mem_sync_read_data <= mem.exists(mem_address) ? mem[mem_address] : dflt(mem_address);
        end
    end

    // Reference model state: expected memory contents and arbitration history.
    logic [31:0] ref_mem [logic [31:0]];
    int lose_cnt = 0;
    bit last_d = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".i_ready"}, {31'd0, i_req_ready}, 32'd0);
        chk({tag, ".d_ready"}, {31'd0, d_req_ready}, 32'd0);
        chk({tag, ".mem_req"}, {31'd0, mem_request}, 32'd0);
        chk({tag, ".i_rsp"}, {31'd0, i_rsp_valid}, 32'd0);
        chk({tag, ".d_rsp"}, {31'd0, d_rsp_valid}, 32'd0);
    endtask

    // One complete transaction starting at a negedge in IDLE; returns who won.
    task automatic txn(input bit iv, input logic [31:0] ia, input bit dv, input bit dw,
                       input logic [31:0] da, input logic [31:0] dd, output bit won_d);
        bit exp_d;
        logic [31:0] ea, er;
        if (iv && dv) begin
`ifdef MEM_ARB_RR_EN
            exp_d = !last_d;
`else
            exp_d = (lose_cnt != MW);
`endif
        end else begin
            exp_d = dv;
        end
        if (!exp_d) lose_cnt = 0;
        else if (iv && lose_cnt < 255) lose_cnt++;
        last_d = exp_d;
        ea = exp_d ? da : ia;
        if (exp_d && dw) begin
            ref_mem[ea] = dd;
            er = 32'd0;
        end else begin
            er = ref_mem.exists(ea) ? ref_mem[ea] : dflt(ea);
        end

        i_req_valid = iv; i_req_addr = ia;
        d_req_valid = dv; d_req_write = dw; d_req_addr = da; d_req_wdata = dd;
        #1;
        chk("i_ready", {31'd0, i_req_ready}, {31'd0, !exp_d});
        chk("d_ready", {31'd0, d_req_ready}, {31'd0, exp_d});
        won_d = exp_d;

        @(negedge clk);
        chk("mem_request", {31'd0, mem_request}, 32'd1);
        chk("mem_address", mem_address, ea);
        chk("mem_write", {31'd0, mem_write}, {31'd0, exp_d && dw});
        if (exp_d && dw) chk("mem_wdata", mem_write_data, dd);
        chk("issue_ready", {30'd0, i_req_ready, d_req_ready}, 32'd0);
        chk("issue_rsp", {30'd0, i_rsp_valid, d_rsp_valid}, 32'd0);
        if (exp_d) d_req_valid = 1'b0; else i_req_valid = 1'b0;

        @(negedge clk);
        chk("i_rsp_valid", {31'd0, i_rsp_valid}, {31'd0, !exp_d});
        chk("d_rsp_valid", {31'd0, d_rsp_valid}, {31'd0, exp_d});
        chk("rsp_rdata", exp_d ? d_rsp_rdata : i_rsp_rdata, er);
        chk("resp_mem_req", {31'd0, mem_request}, 32'd0);
        chk("resp_ready", {30'd0, i_req_ready, d_req_ready}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        bit wd;
        bit ip, dp, dw;
        logic [31:0] ia, da, dd;
        bit exp_fixed [6];
        bit exp_rr [4];
        exp_fixed = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        exp_rr    = '{1'b0, 1'b1, 1'b0, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk_quiet("reset");
        chk("reset.mem_addr", mem_address, 32'd0);
        chk("reset.mem_wdata", mem_write_data, 32'd0);
        chk("reset.mem_write", {31'd0, mem_write}, 32'd0);
        chk("reset.rdata", i_rsp_rdata | d_rsp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Lone fetch, store then load
        txn(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, wd);
        txn(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'hDEADBEEF, wd);
        txn(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, wd);

        // Idle hold
        for (int k = 0; k < 10; k++) begin
            #1 chk_quiet("idle");
            @(negedge clk);
        end

        // Contention from a fresh reset, both ports continuously valid
        rst_n = 1'b0; lose_cnt = 0; last_d = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
`ifdef MEM_ARB_RR_EN
        for (int k = 0; k < 4; k++) begin
            txn(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 32'h0, wd);
            chk("rr_grant_order", {31'd0, wd}, {31'd0, exp_rr[k]});
        end
`else
        for (int k = 0; k < 6; k++) begin
            txn(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 32'h0, wd);
            chk("fixed_grant_order", {31'd0, wd}, {31'd0, exp_fixed[k]});
        end
`endif
        d_req_valid = 1'b0; i_req_valid = 1'b0;

        // Reset during ISSUE drops the access
        i_req_valid = 1'b1; i_req_addr = 32'h44;
        #1 chk("midrst.accept", {31'd0, i_req_ready}, 32'd1);
        @(negedge clk);
        i_req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_quiet("midrst");
        chk("midrst.mem_addr", mem_address, 32'd0);
        chk("midrst.mem_write", {31'd0, mem_write}, 32'd0);
        @(negedge clk);
        chk_quiet("midrst_next");
        rst_n = 1'b1; lose_cnt = 0; last_d = 1'b1;
        @(negedge clk);
        txn(1'b1, 32'h48, 1'b0, 1'b0, 32'h0, 32'h0, wd);

        // Randomized traffic; losers keep their request held until accepted
        ip = 0; dp = 0; dw = 0; ia = '0; da = '0; dd = '0;
        for (int n = 0; n < 200; n++) begin
            if (!ip && $urandom_range(1) == 1) begin
                ip = 1; ia = 32'($urandom_range(15)) << 2;
            end
            if (!dp && $urandom_range(1) == 1) begin
                dp = 1; dw = 1'($urandom_range(1)); da = 32'($urandom_range(15)) << 2; dd = $urandom;
            end
            if (!ip && !dp) begin
                i_req_valid = 1'b0; d_req_valid = 1'b0;
                #1 chk_quiet("rand_idle");
                @(negedge clk);
            end else begin
                txn(ip, ia, dp, dw, da, dd, wd);
                if (wd) dp = 0; else ip = 0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
